// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock through a two-flop synchroniser and releases N_CH resets in staggered order.
// All outputs registered; loss of lock re-asserts every reset 3 edges after the raw flag drops. No backpressure.
module pll_reset_sequencer #(
    parameter int N_CH        = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int STAGGER     = 8,
    parameter int HOLD_CYCLES = 32,
    parameter int LOSS_W      = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              locked,
    output logic [N_CH-1:0]   rst_out,
    output logic              ready,
    output logic              lock_lost,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int QW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [QW-1:0]   Q_LAST  = QW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0]   S_LAST  = SW'(STAGGER - 1);
    localparam logic [HW-1:0]   H_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [N_CH-1:0] ALL_ON  = {N_CH{1'b1}};
    localparam logic [N_CH-1:0] FIRST_R = ALL_ON << 1;

    typedef enum logic [1:0] {
        QUALIFY,
        RELEASE,
        RUN,
        HOLD
    } state_t;

    state_t      state;
    logic        sync_a;
    logic        locked_s;
    logic [QW-1:0] qcnt;
    logic [SW-1:0] scnt;
    logic [HW-1:0] hcnt;
    logic        lose;

    always_comb begin
        lose = 1'b0;
        if ((state == RELEASE || state == RUN) && !locked_s) begin
            lose = 1'b1;
        end
    end

    // rst_out doubles as the release pointer: each stagger shifts one more zero in from bit 0,
    // so released channels can never re-assert individually.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_a     <= 1'b0;
            locked_s   <= 1'b0;
            state      <= QUALIFY;
            qcnt       <= '0;
            scnt       <= '0;
            hcnt       <= '0;
            rst_out    <= ALL_ON;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            sync_a    <= locked;
            locked_s  <= sync_a;
            lock_lost <= 1'b0;
            if (lose) begin
                state     <= HOLD;
                hcnt      <= '0;
                rst_out   <= ALL_ON;
                ready     <= 1'b0;
                lock_lost <= 1'b1;
                if (loss_count != {LOSS_W{1'b1}}) begin
                    loss_count <= loss_count + 1'b1;
                end
            end else begin
                case (state)
                    QUALIFY: begin
                        if (!locked_s) begin
                            qcnt <= '0;
                        end else if (qcnt == Q_LAST) begin
                            state   <= RELEASE;
                            qcnt    <= '0;
                            scnt    <= '0;
                            rst_out <= FIRST_R;
                        end else begin
                            qcnt <= qcnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (rst_out == '0) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else if (scnt == S_LAST) begin
                            scnt    <= '0;
                            rst_out <= rst_out << 1;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    RUN: begin
                        ready <= 1'b1;
                    end
                    HOLD: begin
                        // Lock state is ignored here; requalification starts from zero afterwards.
                        if (hcnt == H_LAST) begin
                            state <= QUALIFY;
                            qcnt  <= '0;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= QUALIFY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus threads queue expected output snapshots, monitors pop them on every output change.
module tb_pll_reset_sequencer;

    typedef struct packed {
        logic [3:0] rst_out;
        logic       ready;
        logic       lock_lost;
        logic [7:0] loss_count;
    } obs_t;

    typedef struct packed {
        int   cyc;
        obs_t o;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, locked;
    logic [3:0] rst_out;
    logic       ready, lock_lost;
    logic [7:0] loss_count;

    logic       rst2, locked2;
    logic [0:0] rst_out2;
    logic       ready2, lock_lost2;
    logic [1:0] loss_count2;

    pll_reset_sequencer dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .locked     (locked),
        .rst_out    (rst_out),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    pll_reset_sequencer #(
        .N_CH        (1),
        .LOCK_CYCLES (2),
        .STAGGER     (3),
        .HOLD_CYCLES (4),
        .LOSS_W      (2)
    ) dut_small (
        .CLOCK_50   (clk),
        .reset      (rst2),
        .locked     (locked2),
        .rst_out    (rst_out2),
        .ready      (ready2),
        .lock_lost  (lock_lost2),
        .loss_count (loss_count2)
    );

    ev_t q_main[$];
    ev_t q_aux[$];
    int  checks = 0;
    int  failures = 0;

    task automatic push_ev(input int which, input int c, input logic [3:0] r, input logic rd,
                           input logic ll, input logic [7:0] lc);
        ev_t e;
        e.cyc          = c;
        e.o.rst_out    = r;
        e.o.ready      = rd;
        e.o.lock_lost  = ll;
        e.o.loss_count = lc;
        if (which == 0) q_main.push_back(e);
        else            q_aux.push_back(e);
    endtask

    // Full staggered release of the 4-channel instance starting at edge rel.
    task automatic push_release(input int rel, input logic [7:0] lc);
        push_ev(0, rel,      4'hE, 1'b0, 1'b0, lc);
        push_ev(0, rel + 8,  4'hC, 1'b0, 1'b0, lc);
        push_ev(0, rel + 16, 4'h8, 1'b0, 1'b0, lc);
        push_ev(0, rel + 24, 4'h0, 1'b0, 1'b0, lc);
        push_ev(0, rel + 25, 4'h0, 1'b1, 1'b0, lc);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic compare(input string tag, input ev_t e, input obs_t a);
        checks++;
        if (e.cyc != cyc || e.o !== a) begin
            failures++;
            $display("FAIL %s: got cycle %0d rst_out=%h ready=%b lock_lost=%b loss_count=%0d, expected cycle %0d rst_out=%h ready=%b lock_lost=%b loss_count=%0d",
                     tag, cyc, a.rst_out, a.ready, a.lock_lost, a.loss_count,
                     e.cyc, e.o.rst_out, e.o.ready, e.o.lock_lost, e.o.loss_count);
        end
    endtask

    task automatic unexpected(input string tag, input obs_t a);
        checks++;
        failures++;
        $display("FAIL %s: unexpected output change at cycle %0d rst_out=%h ready=%b lock_lost=%b loss_count=%0d, expected no change",
                 tag, cyc, a.rst_out, a.ready, a.lock_lost, a.loss_count);
    endtask

    obs_t act_m, prev_m, act_a, prev_a;
    bit   first_m = 1'b1;
    bit   first_a = 1'b1;
    ev_t  pop_m, pop_a;

    initial begin
        forever begin
            @(clk);
            #1;
            act_m = '{rst_out, ready, lock_lost, loss_count};
            if (first_m || act_m !== prev_m) begin
                if (q_main.size() == 0) unexpected("main", act_m);
                else begin
                    pop_m = q_main.pop_front();
                    compare("main", pop_m, act_m);
                end
            end
            prev_m  = act_m;
            first_m = 1'b0;
        end
    end

    initial begin
        forever begin
            @(clk);
            #1;
            act_a = '{{3'b000, rst_out2}, ready2, lock_lost2, {6'b0, loss_count2}};
            if (first_a || act_a !== prev_a) begin
                if (q_aux.size() == 0) unexpected("small", act_a);
                else begin
                    pop_a = q_aux.pop_front();
                    compare("small", pop_a, act_a);
                end
            end
            prev_a  = act_a;
            first_a = 1'b0;
        end
    end

    task automatic stim_main();
        wait_cyc(3);
        rst    = 1'b0;
        locked = 1'b1;
        push_release(21, 8'd0);
        // Lock drop in RUN, plus a lock glitch while holding that must be ignored.
        wait_cyc(53);
        locked = 1'b0;
        push_ev(0, 56, 4'hF, 1'b0, 1'b1, 8'd1);
        push_ev(0, 57, 4'hF, 1'b0, 1'b0, 8'd1);
        wait_cyc(56);
        locked = 1'b1;
        wait_cyc(63);
        locked = 1'b0;
        wait_cyc(64);
        locked = 1'b1;
        push_release(104, 8'd1);
        // Second loss, then async reset during HOLD clears the counter at once.
        wait_cyc(140);
        locked = 1'b0;
        push_ev(0, 143, 4'hF, 1'b0, 1'b1, 8'd2);
        push_ev(0, 144, 4'hF, 1'b0, 1'b0, 8'd2);
        wait_cyc(150);
        rst = 1'b1;
        push_ev(0, 150, 4'hF, 1'b0, 1'b0, 8'd0);
        wait_cyc(152);
        rst    = 1'b0;
        locked = 1'b1;
        // One-cycle glitch at qcnt=10 restarts qualification.
        wait_cyc(162);
        locked = 1'b0;
        wait_cyc(163);
        locked = 1'b1;
        push_ev(0, 181, 4'hE, 1'b0, 1'b0, 8'd0);
        push_ev(0, 189, 4'hC, 1'b0, 1'b0, 8'd0);
        // Loss mid-release after channel 1 is out.
        wait_cyc(190);
        locked = 1'b0;
        push_ev(0, 193, 4'hF, 1'b0, 1'b1, 8'd1);
        push_ev(0, 194, 4'hF, 1'b0, 1'b0, 8'd1);
        wait_cyc(193);
        locked = 1'b1;
        push_ev(0, 241, 4'hE, 1'b0, 1'b0, 8'd1);
        push_ev(0, 249, 4'hC, 1'b0, 1'b0, 8'd1);
        // Async reset during RELEASE.
        wait_cyc(252);
        rst = 1'b1;
        push_ev(0, 252, 4'hF, 1'b0, 1'b0, 8'd0);
        wait_cyc(255);
        rst = 1'b0;
        push_release(273, 8'd0);
        wait_cyc(310);
    endtask

    task automatic stim_aux();
        logic [7:0] lc;
        wait_cyc(3);
        rst2    = 1'b0;
        locked2 = 1'b1;
        push_ev(1, 7, 4'h0, 1'b0, 1'b0, 8'd0);
        push_ev(1, 8, 4'h0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            lc = (i + 1 > 3) ? 8'd3 : 8'(i + 1);
            wait_cyc(15 + 15 * i);
            locked2 = 1'b0;
            push_ev(1, 18 + 15 * i, 4'h1, 1'b0, 1'b1, lc);
            push_ev(1, 19 + 15 * i, 4'h1, 1'b0, 1'b0, lc);
            wait_cyc(18 + 15 * i);
            locked2 = 1'b1;
            push_ev(1, 24 + 15 * i, 4'h0, 1'b0, 1'b0, lc);
            push_ev(1, 25 + 15 * i, 4'h0, 1'b1, 1'b0, lc);
        end
        wait_cyc(100);
    endtask

    initial begin
        rst     = 1'b0;
        rst2    = 1'b0;
        locked  = 1'b0;
        locked2 = 1'b0;
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        push_ev(0, 1, 4'hF, 1'b0, 1'b0, 8'd0);
        push_ev(1, 1, 4'h1, 1'b0, 1'b0, 8'd0);
        fork
            stim_main();
            stim_aux();
        join
        wait_cyc(320);
        checks++;
        if (q_main.size() != 0) begin
            failures++;
            $display("FAIL main_drain: %0d expected events never seen (next due cycle %0d), expected 0",
                     q_main.size(), q_main[0].cyc);
        end
        checks++;
        if (q_aux.size() != 0) begin
            failures++;
            $display("FAIL small_drain: %0d expected events never seen (next due cycle %0d), expected 0",
                     q_aux.size(), q_aux[0].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
